// File: rtl/control_pkg.sv
// Shared encodings for the stacked microsequencer.
//   mode_e  : next_mode field from the control store (11x values are reserved)
//   state_e : sequencer run state
//   fault_e : fault_code reported while in the fault state
package control_pkg;

  typedef enum logic [2:0] {
    MODE_SEQ      = 3'b000,
    MODE_DISPATCH = 3'b001,
    MODE_BRANCH   = 3'b010,
    MODE_CALL     = 3'b011,
    MODE_RETURN   = 3'b100,
    MODE_HALT     = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_OVERFLOW  = 2'b01,
    FC_UNDERFLOW = 2'b10,
    FC_ILLEGAL   = 2'b11
  } fault_e;

endpackage

// File: rtl/microsequencer_stacked_return_stack.sv
// LIFO return-address stack for the microsequencer.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   push, pop      : single-cycle push / pop requests (never both at once)
//   clear          : synchronous empty, used on restart
//   push_data      : address written on push
//   top            : most recently pushed entry (don't-care when empty)
//   level          : number of occupied entries
//   full, empty    : level == DEPTH, level == 0
// Pushes while full and pops while empty are dropped; the caller turns
// those into faults.
module return_stack #(
  parameter  int unsigned WIDTH = 5,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH + 1),
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic [IW-1:0]    top_idx;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign top_idx = IW'(level_q - 1'b1);
  assign top     = mem_q[top_idx];

  always_comb begin
    level_d = level_q;
    if (clear)
      level_d = '0;
    else if (push && !full)
      level_d = level_q + 1'b1;
    else if (pop && !empty)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      level_q <= '0;
    else
      level_q <= level_d;
  end

  // Storage is not reset: entries above level are never read.
  always_ff @(posedge clock) begin
    if (push && !full && !clear)
      mem_q[level_q[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/microsequencer_stacked.sv
// Microprogram sequencer with hardware return stack and halt/fault FSM.
//   clock, reset_n    : rising-edge clock, asynchronous active-low reset
//   enable            : advance when 1, hold everything when 0
//   restart           : leave HALTED/FAULT back to RUN at RESET_ADDRESS
//   next_mode         : SEQ/DISPATCH/BRANCH/CALL/RETURN/HALT, 11x reserved
//   next_address      : control-store target address
//   cond_select/_invert, conditions : branch condition selection
//   dispatch_address  : opcode dispatcher start address
//   address           : current microaddress (registered)
//   running/halted/fault : one-hot state flags
//   fault_code        : 00 none, 01 overflow, 10 underflow, 11 illegal mode
//   stack_level       : occupied return-stack entries
module microsequencer_stacked
  import control_pkg::*;
#(
  parameter  int unsigned            ADDR_WIDTH    = 5,
  parameter  int unsigned            COND_WIDTH    = 4,
  parameter  int unsigned            STACK_DEPTH   = 4,
  parameter  logic [ADDR_WIDTH-1:0]  RESET_ADDRESS = '0,
  localparam int unsigned            CSW = (COND_WIDTH > 1) ? $clog2(COND_WIDTH) : 1,
  localparam int unsigned            LW  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [2:0]            next_mode,
  input  logic [ADDR_WIDTH-1:0] next_address,
  input  logic [CSW-1:0]        cond_select,
  input  logic                  cond_invert,
  input  logic [COND_WIDTH-1:0] conditions,
  input  logic [ADDR_WIDTH-1:0] dispatch_address,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  running,
  output logic                  halted,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [LW-1:0]         stack_level
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  state_e                state_q, state_d;
  fault_e                fc_q, fc_d;
  logic                  push, pop, clear;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  stack_full, stack_empty;
  logic                  cond_bit;

  assign addr_inc = addr_q + 1'b1;

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (addr_inc),
    .top       (stack_top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Out-of-range selects (possible when COND_WIDTH is not a power of two)
  // fall through to 0.
  always_comb begin
    cond_bit = 1'b0;
    for (int unsigned i = 0; i < COND_WIDTH; i++)
      if (cond_select == CSW'(i))
        cond_bit = conditions[i];
  end

  always_comb begin
    addr_d  = addr_q;
    state_d = state_q;
    fc_d    = fc_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (enable) begin
      case (state_q)
        ST_RUN: begin
          case (next_mode)
            MODE_SEQ:
              addr_d = (next_address == '1) ? dispatch_address : next_address;
            MODE_DISPATCH:
              addr_d = dispatch_address;
            MODE_BRANCH:
              addr_d = (cond_bit ^ cond_invert) ? next_address : addr_inc;
            MODE_CALL: begin
              if (stack_full) begin
                state_d = ST_FAULT;
                fc_d    = FC_OVERFLOW;
              end else begin
                push   = 1'b1;
                addr_d = next_address;
              end
            end
            MODE_RETURN: begin
              if (stack_empty) begin
                state_d = ST_FAULT;
                fc_d    = FC_UNDERFLOW;
              end else begin
                pop    = 1'b1;
                addr_d = stack_top;
              end
            end
            MODE_HALT:
              state_d = ST_HALTED;
            default: begin
              state_d = ST_FAULT;
              fc_d    = FC_ILLEGAL;
            end
          endcase
        end
        default: begin
          if (restart) begin
            addr_d  = RESET_ADDRESS;
            state_d = ST_RUN;
            fc_d    = FC_NONE;
            clear   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= RESET_ADDRESS;
      state_q <= ST_RUN;
      fc_q    <= FC_NONE;
    end else begin
      addr_q  <= addr_d;
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  assign address    = addr_q;
  assign running    = (state_q == ST_RUN);
  assign halted     = (state_q == ST_HALTED);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fc_q;

endmodule
